// File: rtl/dmem_responder.sv
// Data memory responder: one outstanding request, fixed WAIT_CYCLES latency, single-cycle response.
// Also watches writes to TOHOST_ADDR and keeps a sticky completion flag plus the last value written.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_done,
  output logic [31:0] o_done_value
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic [31:0] r_done_value;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [29:0]   w_widx;
  logic [AW-1:0] w_midx;
  logic          w_oor;
  logic          w_tohost;
  logic          w_err;
  logic          w_resp;

  assign w_widx   = r_addr[31:2];
  assign w_midx   = w_widx[AW-1:0];
  assign w_oor    = (w_widx >= 30'(DEPTH_WORDS));
  assign w_tohost = (r_addr == TOHOST_ADDR);
  // The monitor address is never a fault, even if it lies beyond the array.
  assign w_err    = (r_addr[1:0] != 2'b00) || (w_oor && !w_tohost);
  assign w_resp   = (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_done       <= 1'b0;
      r_done_value <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_resp && r_we && !w_err && w_tohost) begin
        r_done       <= 1'b1;
        r_done_value <= r_wdata;
      end
    end
  end

  // Storage is deliberately left out of reset; a reset only blocks the pending write.
  always_ff @(posedge clk) begin
    if (!reset && w_resp && r_we && !w_err && !w_oor) begin
      r_mem[w_midx] <= r_wdata;
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    if (w_resp && !r_we && !w_err) begin
      o_rdata = (w_tohost && w_oor) ? r_done_value : r_mem[w_midx];
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_rsp_valid  = w_resp;
  assign o_err        = w_resp && w_err;
  assign o_done       = r_done;
  assign o_done_value = r_done_value;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: unit 0 uses defaults (WAIT_CYCLES=2), unit 1 has zero wait states and an out-of-range monitor address.
// Both are checked against an array-based model of memory contents, faults and the completion monitor.
module tb_dmem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] TOHOST0 = 32'h64;
  localparam logic [31:0] TOHOST1 = 32'h400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid  [2];
  logic        we_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s[2];
  logic        ready  [2];
  logic        rsp    [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic        done   [2];
  logic [31:0] dval   [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  bit          m_done  [2];
  logic [31:0] m_dval  [2];
  logic [31:0] m_tohost[2];
  int          m_lat   [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .TOHOST_ADDR(TOHOST0)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(valid[0]), .o_req_ready(ready[0]),
    .i_we(we_s[0]), .i_addr(addr_s[0]), .i_wdata(wdata_s[0]),
    .o_rsp_valid(rsp[0]), .o_rdata(rdata[0]), .o_err(err[0]),
    .o_done(done[0]), .o_done_value(dval[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .TOHOST_ADDR(TOHOST1)) dut0 (
    .clk(clk), .reset(reset),
    .i_req_valid(valid[1]), .o_req_ready(ready[1]),
    .i_we(we_s[1]), .i_addr(addr_s[1]), .i_wdata(wdata_s[1]),
    .o_rsp_valid(rsp[1]), .o_rdata(rdata[1]), .o_err(err[1]),
    .o_done(done[1]), .o_done_value(dval[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault(input int u, input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH && a != m_tohost[u]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) valid[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      m_dval[i] = 32'd0;
    end
  endtask

  task automatic txn(input int u, input bit we, input logic [31:0] a, input logic [31:0] wd);
    int n;
    bit f;
    bit oor;
    @(negedge clk);
    chk("ready_idle", 32'(ready[u]), 32'd1);
    valid[u] = 1'b1; we_s[u] = we; addr_s[u] = a; wdata_s[u] = wd;
    @(posedge clk);
    @(negedge clk);
    valid[u] = 1'b0;
    n = 1;
    while (!rsp[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(m_lat[u]));
    f   = m_fault(u, a);
    oor = (a >> 2) >= DEPTH;
    chk("err", 32'(err[u]), 32'(f));
    if (we || f) chk("rdata_zero", rdata[u], 32'd0);
    else if (a == m_tohost[u] && oor) chk("rdata_tohost", rdata[u], m_dval[u]);
    else if (m_known[u][a >> 2]) chk("rdata", rdata[u], m_mem[u][a >> 2]);
    if (we && !f) begin
      if (!oor) begin
        m_mem[u][a >> 2] = wd;
        m_known[u][a >> 2] = 1'b1;
      end
      if (a == m_tohost[u]) begin
        m_done[u] = 1'b1;
        m_dval[u] = wd;
      end
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp[u]), 32'd0);
    chk("done", 32'(done[u]), 32'(m_done[u]));
    chk("done_value", dval[u], m_dval[u]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int sel;
    m_tohost[0] = TOHOST0; m_tohost[1] = TOHOST1;
    m_lat[0] = 3; m_lat[1] = 1;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0; we_s[u] = 1'b0; addr_s[u] = 32'd0; wdata_s[u] = 32'd0;
      m_done[u] = 1'b0; m_dval[u] = 32'd0;
      for (int i = 0; i < DEPTH; i++) m_known[u][i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", 32'(ready[u]), 32'd1);
      chk("rst_rsp", 32'(rsp[u]), 32'd0);
      chk("rst_rdata", rdata[u], 32'd0);
      chk("rst_err", 32'(err[u]), 32'd0);
      chk("rst_done", 32'(done[u]), 32'd0);
      chk("rst_dval", dval[u], 32'd0);
    end

    // Known contents everywhere so random reads are fully checkable.
    for (int i = 0; i < DEPTH; i++) txn(0, 1'b1, 32'(i * 4), $urandom);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 32'd0);
    txn(0, 1'b1, 32'h64, 32'h19);
    txn(0, 1'b0, 32'h64, 32'd0);
    txn(0, 1'b0, 32'h11, 32'd0);
    txn(0, 1'b0, 32'h100, 32'd0);
    txn(0, 1'b1, 32'h100, 32'h5555);
    txn(0, 1'b0, 32'h10, 32'd0);
    txn(0, 1'b1, 32'h30, 32'hA5A5_0F0F);
    txn(0, 1'b0, 32'h30, 32'd0);
    txn(0, 1'b1, 32'h64, 32'h77);

    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        1:       a = 32'($urandom_range(DEPTH, 1000)) << 2;
        2:       a = TOHOST0;
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      txn(0, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset while a write sits in its wait states.
    txn(0, 1'b1, 32'h20, 32'hCAFE_0020);
    @(negedge clk);
    valid[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("abort_ready_busy", 32'(ready[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_done[u] = 1'b0;
      m_dval[u] = 32'd0;
    end
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rsp", 32'(rsp[0]), 32'd0);
      chk("abort_ready", 32'(ready[0]), 32'd1);
      @(negedge clk);
    end
    chk("abort_done", 32'(done[0]), 32'd0);
    txn(0, 1'b0, 32'h20, 32'd0);

    // Zero wait states, request held continuously.
    txn(1, 1'b1, 32'h8, 32'h0BAD_F00D);
    @(negedge clk);
    valid[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h8;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b_rsp", 32'(rsp[1]), 32'(i % 2));
      chk("b2b_ready", 32'(ready[1]), 32'((i + 1) % 2));
      chk("b2b_rdata", rdata[1], (i % 2 == 1) ? 32'h0BAD_F00D : 32'd0);
    end
    valid[1] = 1'b0;
    @(negedge clk);

    // Monitor address beyond the array on unit 1.
    txn(1, 1'b1, TOHOST1, 32'h0000_0042);
    txn(1, 1'b0, TOHOST1, 32'd0);
    txn(1, 1'b1, TOHOST1, 32'h0000_0099);
    txn(1, 1'b0, TOHOST1, 32'd0);
    txn(1, 1'b0, 32'h8, 32'd0);
    for (int k = 0; k < 30; k++) begin
      a = ($urandom_range(0, 3) == 0) ? TOHOST1 : (32'($urandom_range(0, DEPTH - 1)) << 2);
      txn(1, 1'($urandom_range(0, 1)), a, $urandom);
    end

    do_reset();
    chk("final_done0", 32'(done[0]), 32'd0);
    chk("final_done1", 32'(done[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit memory words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h64, byte address of the completion monitor.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req_valid  in  1  initiator presents a request.
REQ-007 SHALL have port o_req_ready  out  1  responder can accept a request this cycle.
REQ-008 SHALL have port i_we  in  1  1 = write, 0 = read.
REQ-009 SHALL have port i_addr  in  32  byte address (ALUResult side).
REQ-010 SHALL have port i_wdata  in  32  write data (WriteData side).
REQ-011 SHALL have port o_rsp_valid  out  1  one-cycle response strobe.
REQ-012 SHALL have port o_rdata  out  32  read data, valid while o_rsp_valid=1.
REQ-013 SHALL have port o_err  out  1  access fault, valid while o_rsp_valid=1.
REQ-014 SHALL have port o_done  out  1  sticky: a write to TOHOST_ADDR has occurred.
REQ-015 SHALL have port o_done_value  out  32  data of the most recent TOHOST_ADDR write.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; o_req_ready=1 only in IDLE.
REQ-017 Handshake: request accepted on a rising edge where i_req_valid=1 and o_req_ready=1; i_we, i_addr, i_wdata captured on that edge.
REQ-018 On accept: WAIT_CYCLES=0 -> RESP next; otherwise -> WAIT with counter loaded to WAIT_CYCLES.
REQ-019 WAIT: counter decrements each cycle; when counter=1, next state RESP.
REQ-020 Latency: accept on edge k -> o_rsp_valid=1 for exactly one cycle, cycle k+1+WAIT_CYCLES.
REQ-021 RESP always returns to IDLE next cycle; no response backpressure; one outstanding request; i_req_valid outside IDLE ignored.
REQ-022 Read: o_rdata = mem[addr[31:2]] from the captured address during RESP; o_rdata=0 when o_rsp_valid=0 and on writes.
REQ-023 Write: mem[addr[31:2]] updated on the rising edge ending RESP; a read accepted later returns the new value.
REQ-024 Fault: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> o_err=1 in RESP, o_rdata=0, no memory write.
REQ-025 Monitor: non-faulting write to TOHOST_ADDR sets o_done=1 and o_done_value=wdata on the edge ending RESP, in addition to the memory write; later such writes overwrite o_done_value, o_done stays 1.
REQ-026 TOHOST_ADDR outside memory range -> monitor still captures; access not faulted; memory not written; reads return o_done_value.
REQ-027 Arithmetic: word index = captured addr[31:2] compared unsigned against DEPTH_WORDS; wait counter 4 bits, no wrap.

Reset
REQ-028 While reset=1 on an edge: state->IDLE, counter->0, o_done->0, o_done_value->0.
REQ-029 After reset: o_req_ready=1, o_rsp_valid=0, o_rdata=0, o_err=0.
REQ-030 Reset in WAIT or RESP aborts the request: no response, no memory write, no monitor update.
REQ-031 Memory contents SHALL NOT be cleared by reset; power-up contents undefined.

Verification
REQ-032 Write 0xDEADBEEF to 0x10, then read 0x10 (WAIT_CYCLES=2) -> each rsp_valid 3 cycles after accept; read o_rdata=0xDEADBEEF, o_err=0.
REQ-033 Write 25 (0x19) to 0x64 -> o_done=1, o_done_value=0x19 after write response; read 0x64 returns 0x19.
REQ-034 Read 0x11 (misaligned) and 0x100 (index 64 >= DEPTH) -> o_err=1, o_rdata=0; prior contents of 0x10 unchanged.
REQ-035 Write 0x1234 to 0x20, reset during WAIT -> no rsp_valid; ready=1 after reset; read 0x20 returns pre-existing value, o_done=0.
REQ-036 WAIT_CYCLES=0, back-to-back valid held high -> accept every 2 cycles, rsp_valid the cycle after each accept, ready low in RESP.
REQ-037 Read-after-write to same word 0x30 issued immediately after write response -> returns the written value.
